// File: rtl/rand_delay_gate.sv
// Per-packet random delay gate for AXI4-Stream.
// Holds each packet for base + masked PRBS cycles, then passes it through.
module rand_delay_gate #(
    parameter int DATA_WIDTH = 256,
    parameter int PRBS_WIDTH = 31,
    parameter int CNT_WIDTH  = 24
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [PRBS_WIDTH-1:0]   prbs_do,
    output logic                    prbs_advance,
    input  logic                    cfg_enable,
    input  logic [CNT_WIDTH-1:0]    cfg_base,
    input  logic [CNT_WIDTH-1:0]    cfg_mask,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic [31:0]             stat_pkt_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        PASS
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH:0]   sum;
    logic [CNT_WIDTH-1:0] dly;
    logic                 in_pass;
    logic                 load;
    logic                 unused_prbs;

    assign unused_prbs = ^prbs_do;

    assign sum = {1'b0, cfg_base}
               + {1'b0, prbs_do[CNT_WIDTH-1:0] & cfg_mask};
    assign dly = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];

    assign in_pass = (state == PASS);
    assign load    = (state == IDLE) && s_axis_tvalid;

    // Gated by rstn so a held tvalid cannot step the PRBS during reset.
    assign prbs_advance = rstn && load && cfg_enable;

    assign m_axis_tvalid = in_pass && s_axis_tvalid;
    assign s_axis_tready = in_pass && m_axis_tready;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tlast  = s_axis_tlast;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            cnt          <= '0;
            stat_pkt_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axis_tvalid) begin
                        if (cfg_enable) begin
                            cnt   <= dly;
                            state <= (dly != '0) ? WAIT : PASS;
                        end else begin
                            state <= PASS;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == CNT_WIDTH'(1)) begin
                        state <= PASS;
                    end else begin
                        cnt <= cnt - CNT_WIDTH'(1);
                    end
                end
                PASS: begin
                    if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                        state        <= IDLE;
                        stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rand_delay_gate.sv
// Scoreboard bench for rand_delay_gate (8-bit delay counter, 32-bit data).
// One process drives stimulus and samples outputs on the falling edge.
module tb_rand_delay_gate;

    logic        clk = 1'b0;
    logic        rstn;
    logic [30:0] prbs_do;
    logic        prbs_advance;
    logic        cfg_enable;
    logic [7:0]  cfg_base;
    logic [7:0]  cfg_mask;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [31:0] stat_pkt_cnt;

    rand_delay_gate #(
        .DATA_WIDTH(32),
        .PRBS_WIDTH(31),
        .CNT_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .prbs_do      (prbs_do),
        .prbs_advance (prbs_advance),
        .cfg_enable   (cfg_enable),
        .cfg_base     (cfg_base),
        .cfg_mask     (cfg_mask),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .stat_pkt_cnt (stat_pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } sb_t;

    sb_t sb[$];
    int  nerr = 0;
    int  nchk = 0;
    int  cyc = 0;
    int  exp_first = 0;
    int  exp_pkts = 0;
    int  adv_cnt = 0;
    int  adv_cyc = -1;
    bit  in_pkt = 1'b0;
    bit  hs = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    task automatic mon();
        sb_t e;
        if (prbs_advance) begin
            adv_cnt++;
            adv_cyc = cyc;
        end
        if (m_axis_tvalid) begin
            chk("mirror", 64'(s_axis_tready), 64'(m_axis_tready));
            if (!in_pkt) begin
                chk("latency", 64'(cyc), 64'(exp_first));
                in_pkt = 1'b1;
            end
            if (m_axis_tready) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("data", 64'(m_axis_tdata), 64'(e.data));
                    chk("keep", 64'(m_axis_tkeep), 64'(e.keep));
                    chk("last", 64'(m_axis_tlast), 64'(e.last));
                end
                if (m_axis_tlast) in_pkt = 1'b0;
            end
        end
        hs = s_axis_tvalid && s_axis_tready;
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send_pkt(input int n, input bit en, input logic [7:0] base,
                            input logic [7:0] mask, input logic [30:0] prbs,
                            input bit bp);
        logic [31:0] dat[8];
        logic [3:0]  kp[8];
        sb_t         e;
        int          d, t0, a0, i, wc, k, last_c;
        d = en ? int'(base) + int'(prbs[7:0] & mask) : 0;
        if (d > 255) d = 255;
        for (int j = 0; j < n; j++) begin
            dat[j] = $urandom;
            kp[j]  = 4'($urandom);
            e.data = dat[j];
            e.keep = kp[j];
            e.last = (j == n - 1);
            sb.push_back(e);
        end
        cfg_enable    = en;
        cfg_base      = base;
        cfg_mask      = mask;
        prbs_do       = prbs;
        t0            = cyc;
        exp_first     = t0 + 1 + d;
        a0            = adv_cnt;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = dat[0];
        s_axis_tkeep  = kp[0];
        s_axis_tlast  = (n == 1);
        m_axis_tready = 1'b1;
        i = 0; wc = 0; k = 1; last_c = -1;
        while (i < n && wc < 400) begin
            tick();
            // Config churn mid-packet must only affect the next packet
            cfg_enable = 1'($urandom);
            cfg_base   = 8'($urandom);
            cfg_mask   = 8'($urandom);
            prbs_do    = 31'($urandom);
            if (hs) begin
                if (i == n - 1) last_c = cyc - 1;
                i++;
                wc = 0;
                if (i < n) begin
                    s_axis_tdata = dat[i];
                    s_axis_tkeep = kp[i];
                    s_axis_tlast = (i == n - 1);
                end
            end else begin
                wc++;
            end
            if (bp) m_axis_tready = (k % 3 == 0);
            k++;
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        chk("beats_done", 64'(i), 64'(n));
        if (!bp) chk("span", 64'(last_c - t0), 64'(d + n));
        exp_pkts++;
        chk("pkt_cnt", 64'(stat_pkt_cnt), 64'(exp_pkts));
        chk("adv_count", 64'(adv_cnt - a0), 64'(en));
        if (en) chk("adv_cycle", 64'(adv_cyc), 64'(t0));
        tick();
        chk("idle_tready", 64'(s_axis_tready), 64'd0);
    endtask

    initial begin
        int t0;
        rstn          = 1'b0;
        prbs_do       = '0;
        cfg_enable    = 1'b0;
        cfg_base      = '0;
        cfg_mask      = '0;
        s_axis_tdata  = 32'hA5A5_0001;
        s_axis_tkeep  = 4'hF;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) tick();
        chk("rst_adv", 64'(prbs_advance), 64'd0);
        chk("rst_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_cnt", 64'(stat_pkt_cnt), 64'd0);
        chk("rst_data_thru", 64'(m_axis_tdata), 64'h A5A5_0001);
        rstn = 1'b1;
        repeat (2) tick();

        send_pkt(3, 1'b0, 8'd0, 8'd0, 31'h1234_5678, 1'b0);
        send_pkt(2, 1'b1, 8'd10, 8'h00, 31'h7FFF_FFFF, 1'b0);
        send_pkt(2, 1'b1, 8'd4, 8'h0F, 31'h7FFF_FFF5, 1'b0);
        send_pkt(1, 1'b1, 8'd4, 8'h0F, 31'h0000_0000, 1'b0);
        send_pkt(2, 1'b1, 8'hF0, 8'hFF, 31'h0ABC_DE20, 1'b0);
        send_pkt(1, 1'b1, 8'd0, 8'h00, 31'h0000_0033, 1'b0);
        send_pkt(5, 1'b1, 8'd3, 8'h00, 31'h0000_0000, 1'b1);
        for (int r = 0; r < 3; r++) begin
            send_pkt(1 + r, 1'b1, 8'($urandom_range(0, 12)), 8'h1F,
                     31'($urandom), r == 1);
        end

        // Packet caught in WAIT by reset, never emitted
        cfg_enable    = 1'b1;
        cfg_base      = 8'd20;
        cfg_mask      = 8'h00;
        prbs_do       = 31'($urandom);
        s_axis_tdata  = 32'hDEAD_BEEF;
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        t0            = cyc;
        exp_first     = t0 + 21;
        repeat (16) tick();
        chk("wait_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("wait_tready", 64'(s_axis_tready), 64'd0);
        rstn = 1'b0;
        #1;
        chk("mid_rst_adv", 64'(prbs_advance), 64'd0);
        chk("mid_rst_tready", 64'(s_axis_tready), 64'd0);
        chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("mid_rst_cnt", 64'(stat_pkt_cnt), 64'd0);
        s_axis_tvalid = 1'b0;
        exp_pkts      = 0;
        repeat (2) tick();
        rstn = 1'b1;
        repeat (2) tick();
        chk("post_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        send_pkt(2, 1'b1, 8'd6, 8'h03, 31'h0000_0005, 1'b0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
